// File: rtl/k2red_sched.sv
// Arbiter and tag tracker that shares one K2-RED reduction datapath among N requesters.
// Each requester may have a single operation in flight; results return after a fixed latency.
module k2red_sched #(
    parameter int N   = 4,
    parameter int LAT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [31:0]     cfg_Q,
    input  logic [5:0]      cfg_k1,
    input  logic [5:0]      cfg_k2,
    input  logic [5:0]      cfg_m,
    output logic            cfg_busy,
    input  logic [N-1:0]    req_valid,
    input  logic [64*N-1:0] req_A,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [32*N-1:0] rsp_C,
    input  logic [N-1:0]    rsp_ready,
    output logic [63:0]     dp_A,
    output logic [31:0]     dp_Q,
    output logic [5:0]      dp_k1,
    output logic [5:0]      dp_k2,
    output logic [5:0]      dp_m,
    output logic            dp_valid,
    input  logic [31:0]     dp_C2
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]         outst_q, outst_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [LAT:0]         tag_v_q, tag_v_d;
    logic [LAT:0][PW-1:0] tag_id_q, tag_id_d;
    logic [N-1:0]         rsp_valid_q, rsp_valid_d;
    logic [32*N-1:0]      rsp_c_q, rsp_c_d;
    logic [63:0]          dp_a_q, dp_a_d;
    logic                 dp_valid_q, dp_valid_d;
    logic [31:0]          cfg_q_q, cfg_q_d;
    logic [5:0]           cfg_k1_q, cfg_k1_d;
    logic [5:0]           cfg_k2_q, cfg_k2_d;
    logic [5:0]           cfg_m_q, cfg_m_d;

    logic                 cfg_accept;
    logic                 accept;
    logic                 gnt_found;
    logic [PW-1:0]        gnt_idx;
    logic [N-1:0]         eligible;
    logic [N-1:0]         hs;

    // A config write that lands this cycle takes priority over any grant.
    assign cfg_busy   = |outst_q;
    assign cfg_accept = rst & cfg_we & ~cfg_busy;
    assign eligible   = req_valid & ~outst_q & {N{rst & ~cfg_accept}};
    assign hs         = rsp_valid_q & rsp_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_found && eligible[(int'(ptr_q) + k) % N]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(ptr_q) + k) % N);
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        outst_d     = outst_q & ~hs;
        rsp_valid_d = rsp_valid_q & ~hs;
        rsp_c_d     = rsp_c_q;
        ptr_d       = ptr_q;
        dp_a_d      = dp_a_q;
        dp_valid_d  = accept;
        tag_v_d     = {tag_v_q[LAT-1:0], accept};
        tag_id_d    = {tag_id_q[LAT-1:0], gnt_idx};
        cfg_q_d     = cfg_q_q;
        cfg_k1_d    = cfg_k1_q;
        cfg_k2_d    = cfg_k2_q;
        cfg_m_d     = cfg_m_q;

        if (cfg_accept) begin
            cfg_q_d  = cfg_Q;
            cfg_k1_d = cfg_k1;
            cfg_k2_d = cfg_k2;
            cfg_m_d  = cfg_m;
        end

        if (accept) begin
            outst_d[gnt_idx] = 1'b1;
            dp_a_d           = req_A[int'(gnt_idx)*64 +: 64];
            ptr_d            = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end

        // The owner's rsp_valid is already clear here: one operation per requester.
        if (tag_v_q[LAT]) begin
            rsp_valid_d[tag_id_q[LAT]]              = 1'b1;
            rsp_c_d[int'(tag_id_q[LAT])*32 +: 32] = dp_C2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            outst_q     <= '0;
            ptr_q       <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_c_q     <= '0;
            dp_a_q      <= '0;
            dp_valid_q  <= 1'b0;
            cfg_q_q     <= '0;
            cfg_k1_q    <= '0;
            cfg_k2_q    <= '0;
            cfg_m_q     <= '0;
        end else begin
            outst_q     <= outst_d;
            ptr_q       <= ptr_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_c_q     <= rsp_c_d;
            dp_a_q      <= dp_a_d;
            dp_valid_q  <= dp_valid_d;
            cfg_q_q     <= cfg_q_d;
            cfg_k1_q    <= cfg_k1_d;
            cfg_k2_q    <= cfg_k2_d;
            cfg_m_q     <= cfg_m_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_C     = rsp_c_q;
    assign dp_A      = dp_a_q;
    assign dp_valid  = dp_valid_q;
    assign dp_Q      = cfg_q_q;
    assign dp_k1     = cfg_k1_q;
    assign dp_k2     = cfg_k2_q;
    assign dp_m      = cfg_m_q;

endmodule
